// File: rtl/debounce_pkg.sv
// Shared types and default constants for the debounce_sync block.
package debounce_pkg;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_STABLE_CNT  = 50000;
  localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/debounce_sync_sync_chain.sv
// Multi-flop synchronizer bringing an asynchronous bit into the Clock domain.
module sync_chain #(
  parameter int SYNC_STAGES = 2,
  parameter bit RESET_VAL   = 1'b0
) (
  input  logic Clock,
  input  logic Reset_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      stages <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizer plus stability-count debounce filter with optional edge pulses.
// Edge pulses are built only when DEBOUNCE_EDGE_EN is defined; otherwise Rise/Fall tie to 0.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int STABLE_CNT  = DEF_STABLE_CNT,
  parameter int CNT_W       = DEF_CNT_W,
  parameter bit RESET_VAL   = 1'b0
) (
  input  logic   Clock,
  input  logic   Reset_n,
  input  logic   Din,
  input  logic   Enable,
  output logic   Dout,
  output logic   Rise,
  output logic   Fall,
  output logic   Busy,
  output state_t dbg_state
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic             sync_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q;
  logic             commit;

  sync_chain #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (RESET_VAL)
  ) u_sync (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .d       (Din),
    .q       (sync_q)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      dout_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit) dout_q <= sync_q;
    end
  end

  // A mismatch must persist for STABLE_CNT enabled cycles; any match aborts it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      ST_STABLE: begin
        cnt_d = '0;
        if (sync_q != dout_q) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (sync_q == dout_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (Enable) begin
          if (cnt_q == CNT_LAST) begin
            commit  = 1'b1;
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

`ifdef DEBOUNCE_EDGE_EN
  logic rise_q, fall_q;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= commit & sync_q;
      fall_q <= commit & ~sync_q;
    end
  end

  assign Rise = rise_q;
  assign Fall = fall_q;
`else
  assign Rise = 1'b0;
  assign Fall = 1'b0;
`endif

  assign Dout      = dout_q;
  assign Busy      = (state_q == ST_CHECK);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync with SYNC_STAGES=2, STABLE_CNT=4; handles both edge-enable builds.
module tb_debounce_sync;
  import debounce_pkg::*;

`ifdef DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic   clk;
  logic   rst_n;
  logic   din;
  logic   enable;
  logic   dout;
  logic   rise;
  logic   fall;
  logic   busy;
  state_t dbg_state;

  int checks = 0;
  int errors = 0;

  debounce_sync #(
    .SYNC_STAGES (2),
    .STABLE_CNT  (4),
    .CNT_W       (16),
    .RESET_VAL   (1'b0)
  ) dut (
    .Clock     (clk),
    .Reset_n   (rst_n),
    .Din       (din),
    .Enable    (enable),
    .Dout      (dout),
    .Rise      (rise),
    .Fall      (fall),
    .Busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs changed after this land on the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic e_dout, e_rise, e_busy;
    rst_n  = 1'b0;
    din    = 1'b1;
    enable = 1'b1;
    repeat (3) tick();
    checks++;
    if (dout !== 1'b0 || rise !== 1'b0 || fall !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold got dout=%b rise=%b fall=%b busy=%b exp 0 0 0 0", dout, rise, fall, busy);
    end
    checks++;
    if (dbg_state !== ST_STABLE) begin
      errors++;
      $display("FAIL reset_state got %b exp %b", dbg_state, ST_STABLE);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      e_dout = (e >= 7);
      e_rise = EDGE_EN && (e == 7);
      e_busy = (e >= 3) && (e <= 6);
      checks++;
      if (dout !== e_dout || rise !== e_rise || fall !== 1'b0 || busy !== e_busy) begin
        errors++;
        $display("FAIL reset_release e=%0d got dout=%b rise=%b fall=%b busy=%b exp %b %b 0 %b",
                 e, dout, rise, fall, busy, e_dout, e_rise, e_busy);
      end
    end
  endtask

  task automatic test_clean_fall();
    logic e_dout, e_fall, e_busy;
    din = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      e_dout = !(e >= 7);
      e_fall = EDGE_EN && (e == 7);
      e_busy = (e >= 3) && (e <= 6);
      checks++;
      if (dout !== e_dout || fall !== e_fall || rise !== 1'b0 || busy !== e_busy) begin
        errors++;
        $display("FAIL clean_fall e=%0d got dout=%b fall=%b rise=%b busy=%b exp %b %b 0 %b",
                 e, dout, fall, rise, busy, e_dout, e_fall, e_busy);
      end
    end
  endtask

  task automatic test_bounce();
    logic e_busy;
    din = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 3) din = 1'b0;
      e_busy = (e >= 3) && (e <= 5);
      checks++;
      if (dout !== 1'b0 || rise !== 1'b0 || fall !== 1'b0 || busy !== e_busy) begin
        errors++;
        $display("FAIL bounce e=%0d got dout=%b rise=%b fall=%b busy=%b exp 0 0 0 %b",
                 e, dout, rise, fall, busy, e_busy);
      end
    end
  endtask

  task automatic test_enable_gating();
    logic e_dout, e_rise, e_busy;
    din    = 1'b1;
    enable = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      enable = !((e + 1 >= 5) && (e + 1 <= 9));
      e_dout = (e >= 12);
      e_rise = EDGE_EN && (e == 12);
      e_busy = (e >= 3) && (e <= 11);
      checks++;
      if (dout !== e_dout || rise !== e_rise || fall !== 1'b0 || busy !== e_busy) begin
        errors++;
        $display("FAIL enable_gating e=%0d got dout=%b rise=%b fall=%b busy=%b exp %b %b 0 %b",
                 e, dout, rise, fall, busy, e_dout, e_rise, e_busy);
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    din = 1'b0;
    repeat (4) tick();
    checks++;
    if (busy !== 1'b1 || dout !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre got busy=%b dout=%b exp 1 1", busy, dout);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dout !== 1'b0 || rise !== 1'b0 || fall !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async got dout=%b rise=%b fall=%b busy=%b exp 0 0 0 0", dout, rise, fall, busy);
    end
    tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (dout !== 1'b0 || rise !== 1'b0 || fall !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_after e=%0d got dout=%b rise=%b fall=%b busy=%b exp 0 0 0 0",
                 e, dout, rise, fall, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_fall();
    test_bounce();
    test_enable_gating();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_sync.md
# debounce_sync

- Cleans an asynchronous, bouncing single-bit input (switch or button) into a glitch-free level on the `Clock` domain.
- Sits directly upstream of the negative-edge D flip-flop stage and drives its `D` input.
- Provides metastability synchronization, a stability-count debounce filter, and optional one-cycle edge pulses.
- Runs on the rising edge of `Clock`, so its outputs are settled half a cycle before the downstream falling-edge sample.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer flop count; must be ≥2.
- `STABLE_CNT`, default 50000: consecutive enabled cycles the new level must persist before commit; must be ≥1.
- `CNT_W`, default 16: counter width; must be ≥ clog2(`STABLE_CNT`).
- `RESET_VAL`, default 0: reset level of the synchronizer chain and of `Dout`.

Ports:
- `Clock` in 1: single clock; all logic on the rising edge.
- `Reset_n` in 1: reset, asynchronous and active-low.
- `Din` in 1: raw asynchronous input.
- `Enable` in 1: count-enable tick; the counter advances only when high.
- `Dout` out 1: debounced level; feeds the downstream `D`.
- `Rise` out 1: one-cycle pulse when `Dout` commits 0→1.
- `Fall` out 1: one-cycle pulse when `Dout` commits 1→0.
- `Busy` out 1: high while a candidate change is being qualified.

## Operation
- **Synchronizer:** `Din` passes through `SYNC_STAGES` flops; the last stage is `sync_q`.
- **FSM, two states (`ST_STABLE`, `ST_CHECK`):**
  - `ST_STABLE`, `sync_q == Dout`: hold, count = 0.
  - `ST_STABLE`, `sync_q != Dout`: go to `ST_CHECK`, count = 0.
  - `ST_CHECK`, `sync_q == Dout` (bounce back): return to `ST_STABLE`, count = 0, `Dout` unchanged, no pulse.
  - `ST_CHECK`, `sync_q != Dout`, `Enable` = 1, count == `STABLE_CNT`−1: `Dout` <= `sync_q`, assert `Rise` or `Fall` for one cycle, go to `ST_STABLE`, count = 0.
  - `ST_CHECK`, `sync_q != Dout`, `Enable` = 1, count below that: count += 1.
  - `ST_CHECK`, `Enable` = 0: count holds; the bounce-back check still applies.
- **Outputs:** `Busy` = (state == `ST_CHECK`), registered with the state. `Rise` and `Fall` are never high together.
- **Arithmetic:** the count is unsigned `CNT_W` bits and never exceeds `STABLE_CNT`−1, so it never wraps.
- **Reset mid-operation:** any in-flight qualification is discarded immediately.

## Timing
- **Reset values** (applied asynchronously on `Reset_n` low):
  - synchronizer stages = `RESET_VAL`
  - `Dout` = `RESET_VAL`
  - `Rise` = `Fall` = 0, `Busy` = 0
  - state = `ST_STABLE`, count = 0
- **Reset release:** the first rising edge with `Reset_n` high is normal operation.
- **Latency:** the first edge that samples a new `Din` level is edge 1. With `Enable` held high, `Dout` and the pulse update on edge `SYNC_STAGES`+`STABLE_CNT`+1.
  - With `Enable` toggling, each low cycle adds one cycle.
- **Pulse timing:** `Rise`/`Fall` are high in exactly the cycle following the commit edge, coincident with the new `Dout` value.
- **Busy timing:** `Busy` rises on edge `SYNC_STAGES`+1 and falls on the commit or bounce-back edge.
- **Downstream:** `Dout` is stable from the rising edge through the next falling edge.

## Configuration
- Macro: `DEBOUNCE_EDGE_EN`.
- **Defined:** the edge-detect logic is present; `Rise`/`Fall` behave as specified.
- **Undefined:** the edge logic is omitted; `Rise` and `Fall` remain ports, tied to constant 0. All other behaviour is identical.

## Structure
- **Shared package `debounce_pkg`:**
  - state typedef/constants `ST_STABLE` = 1'b0, `ST_CHECK` = 1'b1
  - default parameter constants `DEF_SYNC_STAGES`, `DEF_STABLE_CNT`
- **Sub-module `sync_chain`:** parameterized `SYNC_STAGES`-deep flop chain with `Clock`/`Reset_n` and reset value `RESET_VAL`.
- **Top level:** FSM, counter and edge logic.

## Test plan
Bench parameters: `SYNC_STAGES`=2, `STABLE_CNT`=4, `RESET_VAL`=0, `Enable`=1 unless noted.
- **Reset:** hold `Reset_n`=0 with `Din`=1 → `Dout`=0, `Rise`=`Fall`=`Busy`=0. Release, keep `Din`=1 → `Dout`=1 on edge 7, with `Rise`=1 for exactly one cycle.
- **Clean fall:** `Din` 1→0 at edge 1 → `Busy`=1 after edge 3, `Dout`=0 and `Fall`=1 after edge 7, `Busy`=0 after edge 7.
- **Bounce rejection:** `Din`=1 for 3 cycles then back to 0 → `Busy` pulses, `Dout` stays 0, no `Rise`.
- **Enable gating:** `Enable`=0 for 5 cycles mid-`ST_CHECK` → commit delayed by exactly 5 cycles.
- **Reset mid-check:** assert `Reset_n`=0 asynchronously while `Busy`=1 → all outputs return to reset values without waiting for a clock edge.
- **Macro off:** build without `DEBOUNCE_EDGE_EN`, rerun the clean-fall scenario → `Dout` timing unchanged, `Rise`=`Fall`=0 throughout.
